// File: rtl/mdu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mdu
// Purpose  : Multi-cycle multiply/divide unit with architectural HI/LO
//            registers. madd/maddu are enabled by defining MDU_MADD_EN.
// Revision : 1.0
// ----------------------------------------------------------------------------
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MADDU = 3'b111;
`endif

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             state_q;
  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [63:0]        pend_q;
  logic               wr_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;

  logic               launch_d;
  logic [CNT_W-1:0]   load_d;
  logic [63:0]        pend_d;
  logic               wr_d;

  logic signed [63:0] smul;
  logic [63:0]        umul;
  logic               b_zero;
  logic               sdiv_ovf;
  logic [31:0]        sdiv_b;
  logic [31:0]        udiv_b;
  logic signed [31:0] sdiv_q;
  logic signed [31:0] sdiv_r;
  logic [31:0]        udiv_q;
  logic [31:0]        udiv_r;

  assign smul = $signed(A) * $signed(B);
  assign umul = {32'b0, A} * {32'b0, B};

  // Divisors are forced to 1 for divide-by-zero (result discarded) and for the
  // signed overflow case, where A/1 already yields quotient 0x80000000, rem 0.
  assign b_zero   = (B == 32'd0);
  assign sdiv_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign sdiv_b   = (b_zero || sdiv_ovf) ? 32'd1 : B;
  assign udiv_b   = b_zero ? 32'd1 : B;

  assign sdiv_q = $signed(A) / $signed(sdiv_b);
  assign sdiv_r = $signed(A) % $signed(sdiv_b);
  assign udiv_q = A / udiv_b;
  assign udiv_r = A % udiv_b;

  always_comb begin
    launch_d = 1'b0;
    load_d   = MULT_LOAD;
    pend_d   = 64'd0;
    wr_d     = 1'b1;
    case (mdop)
      OP_MULT: begin
        launch_d = 1'b1;
        pend_d   = $unsigned(smul);
      end
      OP_MULTU: begin
        launch_d = 1'b1;
        pend_d   = umul;
      end
      OP_DIV: begin
        launch_d = 1'b1;
        load_d   = DIV_LOAD;
        pend_d   = {$unsigned(sdiv_r), $unsigned(sdiv_q)};
        wr_d     = !b_zero;
      end
      OP_DIVU: begin
        launch_d = 1'b1;
        load_d   = DIV_LOAD;
        pend_d   = {udiv_r, udiv_q};
        wr_d     = !b_zero;
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        launch_d = 1'b1;
        pend_d   = {hi_q, lo_q} + $unsigned(smul);
      end
      OP_MADDU: begin
        launch_d = 1'b1;
        pend_d   = {hi_q, lo_q} + umul;
      end
`endif
      default: begin
        launch_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= 64'd0;
      wr_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (launch_d) begin
              pend_q  <= pend_d;
              wr_q    <= wr_d;
              cnt_q   <= load_d;
              busy_q  <= 1'b1;
              state_q <= S_RUN;
            end else if (mdop == OP_MTHI) begin
              hi_q <= A;
            end else if (mdop == OP_MTLO) begin
              lo_q <= A;
            end
          end
        end
        S_RUN: begin
          // Requests arriving while running, including on the final edge, are dropped.
          if (cnt_q == '0) begin
            if (wr_q) begin
              hi_q <= pend_q[63:32];
              lo_q <= pend_q[31:0];
            end
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_mdu
// Purpose  : Self-checking bench for mdu against a behavioural HI/LO model.
//            Expectations follow MDU_MADD_EN when it is defined.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Architectural effect of one accepted request, from sign/magnitude arithmetic.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi_in, input logic [31:0] lo_in,
                          output logic [31:0] hi_out, output logic [31:0] lo_out, output int cyc);
    longint sa, sb, ma, mb, mq, mr, q, r;
    logic [63:0] acc;
    hi_out = hi_in;
    lo_out = lo_in;
    cyc    = 0;
    case (op)
      3'd0, 3'd1, 3'd6, 3'd7: begin
        if (!(op[2] && !MADD)) begin
          if (op[0] == 1'b0) acc = 64'(longint'(int'(a)) * longint'(int'(b)));
          else               acc = {32'b0, a} * {32'b0, b};
          if (op[2]) acc = acc + {hi_in, lo_in};
          hi_out = acc[63:32];
          lo_out = acc[31:0];
          cyc    = MULT_N;
        end
      end
      3'd2: begin
        cyc = DIV_N;
        if (b != 32'd0) begin
          sa = longint'(int'(a));
          sb = longint'(int'(b));
          ma = (sa < 0) ? -sa : sa;
          mb = (sb < 0) ? -sb : sb;
          mq = ma / mb;
          mr = ma - mq * mb;
          q  = ((sa < 0) != (sb < 0)) ? -mq : mq;
          r  = (sa < 0) ? -mr : mr;
          lo_out = q[31:0];
          hi_out = r[31:0];
        end
      end
      3'd3: begin
        cyc = DIV_N;
        if (b != 32'd0) begin
          lo_out = a / b;
          hi_out = a % b;
        end
      end
      3'd4: hi_out = a;
      default: lo_out = a;
    endcase
  endtask

  // Issue one request and follow it until busy drops; returns busy cycles seen.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output bit hl_moved);
    logic [31:0] h0, l0;
    @(negedge clk);
    h0 = HI; l0 = LO;
    start = 1'b1; mdop = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; mdop = 3'($urandom);
    cyc = 0; hl_moved = 1'b0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      if (HI !== h0 || LO !== l0) hl_moved = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", HI); end
    checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", LO); end
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_mult;
    int cyc; bit mv; int ec;
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, cyc, mv);
    model_op(3'd0, 32'hFFFF_FFFE, 32'd3, m_hi, m_lo, m_hi, m_lo, ec);
    checks++; if (cyc != MULT_N) begin errors++; $display("FAIL mult_busy: got %0d want %0d", cyc, MULT_N); end
    checks++; if (mv) begin errors++; $display("FAIL mult_hold: HI/LO changed during busy, got 1 want 0"); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
    checks++; if (LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo: got %h want fffffffa", LO); end
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, mv);
    model_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, m_hi, m_lo, m_hi, m_lo, ec);
    checks++; if (cyc != MULT_N) begin errors++; $display("FAIL multu_busy: got %0d want %0d", cyc, MULT_N); end
    checks++; if (HI !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", HI); end
    checks++; if (LO !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", LO); end
  endtask

  task automatic test_div;
    int cyc; bit mv; int ec;
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, cyc, mv);
    model_op(3'd2, 32'hFFFF_FFF9, 32'd2, m_hi, m_lo, m_hi, m_lo, ec);
    checks++; if (cyc != DIV_N) begin errors++; $display("FAIL div_busy: got %0d want %0d", cyc, DIV_N); end
    checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", LO); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", HI); end
    run_op(3'd3, 32'd7, 32'd0, cyc, mv);
    model_op(3'd3, 32'd7, 32'd0, m_hi, m_lo, m_hi, m_lo, ec);
    checks++; if (cyc != DIV_N) begin errors++; $display("FAIL divz_busy: got %0d want %0d", cyc, DIV_N); end
    checks++; if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD)
      begin errors++; $display("FAIL divz_keep: got %h_%h want ffffffff_fffffffd", HI, LO); end
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc, mv);
    model_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, m_hi, m_lo, m_hi, m_lo, ec);
    checks++; if (HI !== 32'd0 || LO !== 32'h8000_0000)
      begin errors++; $display("FAIL div_ovf: got %h_%h want 00000000_80000000", HI, LO); end
  endtask

  task automatic test_move;
    @(negedge clk);
    start = 1'b1; mdop = 3'd4; A = 32'h1234_5678; B = $urandom;
    @(negedge clk);
    checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL mthi: got %h want 12345678", HI); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", busy); end
    mdop = 3'd5; A = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    checks++; if (LO !== 32'h9ABC_DEF0) begin errors++; $display("FAIL mtlo: got %h want 9abcdef0", LO); end
    checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL mtlo_hi: got %h want 12345678", HI); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy: got %b want 0", busy); end
    m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;
  endtask

  // Every request during a run, including the edge where busy falls, must vanish.
  task automatic test_ignore_busy;
    logic [31:0] a, b;
    int cyc, ec;
    a = $urandom; b = $urandom | 32'h1;
    @(negedge clk);
    start = 1'b1; mdop = 3'd2; A = a; B = b;
    @(negedge clk);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      start = 1'b1; mdop = 3'($urandom_range(0, 7)); A = $urandom; B = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    model_op(3'd2, a, b, m_hi, m_lo, m_hi, m_lo, ec);
    checks++; if (cyc != DIV_N) begin errors++; $display("FAIL ign_busy: got %0d want %0d", cyc, DIV_N); end
    checks++; if (HI !== m_hi || LO !== m_lo)
      begin errors++; $display("FAIL ign_result: got %h_%h want %h_%h", HI, LO, m_hi, m_lo); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || HI !== m_hi || LO !== m_lo)
      begin errors++; $display("FAIL ign_after: got busy=%b %h_%h want 0 %h_%h", busy, HI, LO, m_hi, m_lo); end
  endtask

  task automatic test_reset_midop;
    int cyc; bit mv;
    run_op(3'd4, 32'hDEAD_BEEF, 32'd0, cyc, mv);
    @(negedge clk);
    start = 1'b1; mdop = 3'd0; A = 32'h0001_0003; B = 32'h0002_0005;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL rstmid_hl: got %h_%h want 0_0", HI, LO); end
    repeat (MULT_N + 2) @(negedge clk);
    checks++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
      begin errors++; $display("FAIL rstmid_late: got busy=%b %h_%h want 0 0_0", busy, HI, LO); end
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_madd;
    int cyc, ec; bit mv;
    run_op(3'd4, 32'd0, 32'd0, cyc, mv);
    run_op(3'd5, 32'hFFFF_FFFF, 32'd0, cyc, mv);
    m_hi = 32'd0; m_lo = 32'hFFFF_FFFF;
    run_op(3'd7, 32'd1, 32'd1, cyc, mv);
    model_op(3'd7, 32'd1, 32'd1, m_hi, m_lo, m_hi, m_lo, ec);
    if (MADD) begin
      checks++; if (cyc != MULT_N) begin errors++; $display("FAIL maddu_busy: got %0d want %0d", cyc, MULT_N); end
      checks++; if (HI !== 32'd1 || LO !== 32'd0) begin errors++; $display("FAIL maddu_hl: got %h_%h want 1_0", HI, LO); end
    end else begin
      checks++; if (cyc != 0) begin errors++; $display("FAIL maddu_busy: got %0d want 0", cyc); end
      checks++; if (HI !== 32'd0 || LO !== 32'hFFFF_FFFF)
        begin errors++; $display("FAIL maddu_hl: got %h_%h want 0_ffffffff", HI, LO); end
    end
  endtask

  task automatic test_random;
    logic [2:0] op; logic [31:0] a, b;
    int cyc, ec; bit mv;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 31);
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: a = -a;
        default: ;
      endcase
      run_op(op, a, b, cyc, mv);
      model_op(op, a, b, m_hi, m_lo, m_hi, m_lo, ec);
      checks++; if (cyc != ec) begin errors++; $display("FAIL rnd%0d_busy op=%0d: got %0d want %0d", i, op, cyc, ec); end
      checks++; if (HI !== m_hi || LO !== m_lo)
        begin errors++; $display("FAIL rnd%0d_hl op=%0d a=%h b=%h: got %h_%h want %h_%h", i, op, a, b, HI, LO, m_hi, m_lo); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mdop = 3'd0; A = 32'd0; B = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_move();
    test_ignore_busy();
    test_reset_midop();
    test_madd();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits beside the ALU, downstream of the GRF: consumes the two register-file read buses (rs, rt) and produces HI/LO for mfhi/mflo write-back through the WD mux.
- Provides busy so the controller can hold issue of any HI/LO-touching instruction until the current operation completes.

Parameters:
- MULT_CYCLES, 5, number of cycles busy stays high for mult/multu (≥1).
- DIV_CYCLES, 10, number of cycles busy stays high for div/divu (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to launch mdop using A/B.
- mdop  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd, 111 maddu.
- A  input  32  rs operand (BUSA).
- B  input  32  rt operand (BUSB).
- busy  output  1  operation in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (sampled at posedge clk with reset=1): HI=0, LO=0, busy=0, counter=0, pending result discarded. Reset overrides start and any in-flight operation.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, counter counting down).
- IDLE, start=1, mdop in {mult, multu, div, divu}:
  - At edge k, capture A/B.
  - Compute the 64-bit result into an internal pending register.
  - Load counter with N-1, where N = MULT_CYCLES or DIV_CYCLES.
  - busy<=1, go to RUN.
- RUN:
  - Counter decrements each edge.
  - At the edge where counter==0: HI/LO<=pending, busy<=0, go to IDLE.
  - busy is therefore high for exactly N cycles; new HI/LO are visible from edge k+N.
  - HI/LO keep their old values throughout RUN.
- mthi/mtlo:
  - start=1 in IDLE with mdop=100 sets HI<=A at edge k. mdop=101 sets LO<=A.
  - Latency 1; busy stays 0.
- start while busy=1: ignored entirely, for all mdop values. No restart, no mthi/mtlo effect, operands not re-captured.
- start in the same cycle that busy falls: busy is still 1 at that edge, so the request is ignored. The controller re-issues it the next cycle.
- Arithmetic:
  - mult: signed 32x32→64; HI=upper 32 bits, LO=lower 32 bits.
  - multu: unsigned 32x32→64; same HI/LO split.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned; LO=quotient, HI=remainder.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B==0, div or divu): the operation runs its full DIV_CYCLES with busy asserted; HI and LO are left unchanged at completion.
- A/B may change after edge k without affecting the result.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: mdop 110 (madd, signed) and 111 (maddu, unsigned) launch a MULT_CYCLES operation. pending = {HI,LO} sampled at edge k + A*B, with 64-bit wrap-around and no overflow flag.
- Not defined: mdop 110/111 with start=1 are no-ops; busy stays 0 and HI/LO are unchanged.

Test Plan:
- Reset, then start mult with A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA from edge k+5; HI/LO still 0 during busy.
- start multu with A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- start div with A=-7 (0xFFFFFFF9), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu with A=7, B=0 -> busy 10 cycles; HI/LO unchanged.
- mthi with A=0x12345678, then next cycle mtlo with A=0x9ABCDEF0 -> HI=0x12345678 and LO=0x9ABCDEF0, each one cycle later; busy stays 0. Issue mthi during a running div -> HI unaffected.
- Start mult, assert reset on the 3rd busy cycle -> next edge busy=0, HI=LO=0; the pending result is never written.
- With MDU_MADD_EN defined: HI=0, LO=0xFFFFFFFF, then maddu with A=1, B=1 -> HI=1, LO=0 after 5 cycles. Without the macro, the same stimulus leaves HI/LO unchanged and busy=0.
